counter_bcd_iter: RTL and testbench

//  Sequential, parametrised binary-to-BCD converter using the shift-add-3 (double dabble)

---
 rtl/counter_bcd_iter.sv | 155 +++++++++++++++
 tb/tb_counter_bcd_iter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_bcd_iter.sv
`timescale 1ns/1ps
// counter_bcd_iter
// Iterative binary-to-BCD converter (shift-add-3 / double dabble). Each clock
// performs one iteration, so a conversion takes BIN_WIDTH cycles. There is a
// valid/ready handshake on the input and on the output, and conversions do
// not overlap. Also reports decimal overflow and the count of significant
// digits.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst    synchronous active-high reset
//   i_valid  i_bin is valid
//   o_ready  converter can accept i_bin (IDLE)
//   i_bin    unsigned binary input, BIN_WIDTH bits
//   o_valid  result valid (DONE)
//   i_ready  downstream accepts the result
//   o_bcd    BCD result, digit k at [4k+3:4k], digit 0 = units
//   o_ovf    input >= 10**BCD_DIGITS (o_bcd holds input mod 10**BCD_DIGITS)
//   o_ndig   significant digits in o_bcd (1 when o_bcd == 0)
module counter_bcd_iter #(
    parameter int BIN_WIDTH  = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [BIN_WIDTH-1:0]               i_bin,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [4*BCD_DIGITS-1:0]            o_bcd,
    output logic                               o_ovf,
    output logic [$clog2(BCD_DIGITS+1)-1:0]    o_ndig
);

    localparam int BCD_W  = 4 * BCD_DIGITS;
    localparam int NDIG_W = $clog2(BCD_DIGITS + 1);
    localparam int CNT_W  = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_ready_next;
    logic                w_valid_next;

    logic [BIN_WIDTH-1:0] r_bin;
    logic [BCD_W-1:0]     r_bcd;
    logic                 r_ovf_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ready;
    logic                 r_valid;

    logic [BCD_W-1:0]     w_bcd_adj;
    logic [BCD_W-1:0]     w_bcd_shift;
    logic                 w_carry;
    logic                 w_last;
    logic [NDIG_W-1:0]    w_ndig;

    assign o_ready = r_ready;
    assign o_valid = r_valid;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and next handshake outputs
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_valid) w_state_next = S_SHIFT;
            S_SHIFT: if (w_last)  w_state_next = S_DONE;
            S_DONE:  if (i_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        w_ready_next = (w_state_next == S_IDLE);
        w_valid_next = (w_state_next == S_DONE);
    end

    // Add-3 correction on every digit >= 5, all digits in parallel
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int unsigned k = 0; k < BCD_DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // The bit shifted out of the top digit is the decimal overflow carry
    assign w_carry     = w_bcd_adj[BCD_W-1];
    assign w_bcd_shift = {w_bcd_adj[BCD_W-2:0], r_bin[BIN_WIDTH-1]};
    assign w_last      = (r_cnt == CNT_W'(BIN_WIDTH - 1));

    // Significant digits of the value produced by this iteration
    always_comb begin
        w_ndig = NDIG_W'(1);
        for (int unsigned k = 0; k < BCD_DIGITS; k++) begin
            if (w_bcd_shift[4*k +: 4] != 4'd0) begin
                w_ndig = NDIG_W'(k + 1);
            end
        end
    end

    // Datapath; results are copied to the output registers only on the final
    // iteration so they stay stable through IDLE and SHIFT of the next input.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bin     <= '0;
            r_bcd     <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= '0;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            o_bcd     <= '0;
            o_ovf     <= 1'b0;
            o_ndig    <= '0;
        end else begin
            r_ready <= w_ready_next;
            r_valid <= w_valid_next;
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_bin     <= i_bin;
                        r_bcd     <= '0;
                        r_ovf_acc <= 1'b0;
                        r_cnt     <= '0;
                    end
                end
                S_SHIFT: begin
                    r_bin     <= r_bin << 1;
                    r_bcd     <= w_bcd_shift;
                    r_ovf_acc <= r_ovf_acc | w_carry;
                    r_cnt     <= r_cnt + 1'b1;
                    if (w_last) begin
                        o_bcd  <= w_bcd_shift;
                        o_ovf  <= r_ovf_acc | w_carry;
                        o_ndig <= w_ndig;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_bcd_iter.sv
`timescale 1ns/1ps
// tb_counter_bcd_iter
// Self-checking bench for counter_bcd_iter. Three instances: defaults (8/3),
// narrow output (8/2) for overflow, and wide (16/5). Expected values come from
// a decimal-arithmetic reference model.
module tb_counter_bcd_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Instance A: defaults
    logic        a_rst = 1'b0, a_vi = 1'b0, a_ri = 1'b0;
    logic [7:0]  a_bin = '0;
    logic        a_ro, a_vo, a_ovf;
    logic [11:0] a_bcd;
    logic [1:0]  a_ndig;

    // Instance B: two digits
    logic        b_rst = 1'b0, b_vi = 1'b0, b_ri = 1'b0;
    logic [7:0]  b_bin = '0;
    logic        b_ro, b_vo, b_ovf;
    logic [7:0]  b_bcd;
    logic [1:0]  b_ndig;

    // Instance C: 16-bit, five digits
    logic        c_rst = 1'b0, c_vi = 1'b0, c_ri = 1'b0;
    logic [15:0] c_bin = '0;
    logic        c_ro, c_vo, c_ovf;
    logic [19:0] c_bcd;
    logic [2:0]  c_ndig;

    counter_bcd_iter #(.BIN_WIDTH(8), .BCD_DIGITS(3)) dut_a (
        .i_clk(clk), .i_rst(a_rst), .i_valid(a_vi), .o_ready(a_ro), .i_bin(a_bin),
        .o_valid(a_vo), .i_ready(a_ri), .o_bcd(a_bcd), .o_ovf(a_ovf), .o_ndig(a_ndig)
    );

    counter_bcd_iter #(.BIN_WIDTH(8), .BCD_DIGITS(2)) dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_valid(b_vi), .o_ready(b_ro), .i_bin(b_bin),
        .o_valid(b_vo), .i_ready(b_ri), .o_bcd(b_bcd), .o_ovf(b_ovf), .o_ndig(b_ndig)
    );

    counter_bcd_iter #(.BIN_WIDTH(16), .BCD_DIGITS(5)) dut_c (
        .i_clk(clk), .i_rst(c_rst), .i_valid(c_vi), .o_ready(c_ro), .i_bin(c_bin),
        .o_valid(c_vo), .i_ready(c_ri), .o_bcd(c_bcd), .o_ovf(c_ovf), .o_ndig(c_ndig)
    );

    // ---------------- reference model ----------------
    function automatic longint unsigned pow10(input int d);
        longint unsigned r = 1;
        repeat (d) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] m_bcd(input longint unsigned v, input int d);
        logic [31:0] r = '0;
        longint unsigned m = v % pow10(d);
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic m_ovf(input longint unsigned v, input int d);
        return v >= pow10(d);
    endfunction

    function automatic int m_ndig(input longint unsigned v, input int d);
        longint unsigned m = v % pow10(d);
        int n = 1;
        while (m >= 10) begin
            m = m / 10;
            n++;
        end
        return n;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic conv_a(input logic [7:0] v, output int lat);
        int guard = 0;
        while (!a_ro && guard < 50) begin step(); guard++; end
        a_bin = v; a_vi = 1'b1;
        step();
        a_vi = 1'b0;
        lat = 0;
        while (!a_vo && lat < 100) begin step(); lat++; end
        n_checks++;
        if (a_vo !== 1'b1) begin n_errors++; $display("FAIL timeout_a in=%0d got o_valid=%b want 1", v, a_vo); end
    endtask

    task automatic conv_b(input logic [7:0] v, output int lat);
        int guard = 0;
        while (!b_ro && guard < 50) begin step(); guard++; end
        b_bin = v; b_vi = 1'b1;
        step();
        b_vi = 1'b0;
        lat = 0;
        while (!b_vo && lat < 100) begin step(); lat++; end
        n_checks++;
        if (b_vo !== 1'b1) begin n_errors++; $display("FAIL timeout_b in=%0d got o_valid=%b want 1", v, b_vo); end
    endtask

    task automatic conv_c(input logic [15:0] v, output int lat);
        int guard = 0;
        while (!c_ro && guard < 50) begin step(); guard++; end
        c_bin = v; c_vi = 1'b1;
        step();
        c_vi = 1'b0;
        lat = 0;
        while (!c_vo && lat < 100) begin step(); lat++; end
        n_checks++;
        if (c_vo !== 1'b1) begin n_errors++; $display("FAIL timeout_c in=%0d got o_valid=%b want 1", v, c_vo); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        step(); step();
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        n_checks++; if (a_ro !== 1'b1)    begin n_errors++; $display("FAIL rst_ready got=%b want=1", a_ro); end
        n_checks++; if (a_vo !== 1'b0)    begin n_errors++; $display("FAIL rst_valid got=%b want=0", a_vo); end
        n_checks++; if (a_bcd !== 12'h0)  begin n_errors++; $display("FAIL rst_bcd got=%h want=000", a_bcd); end
        n_checks++; if (a_ovf !== 1'b0)   begin n_errors++; $display("FAIL rst_ovf got=%b want=0", a_ovf); end
        n_checks++; if (a_ndig !== 2'd0)  begin n_errors++; $display("FAIL rst_ndig got=%0d want=0", a_ndig); end
        n_checks++; if (c_ro !== 1'b1)    begin n_errors++; $display("FAIL rst_ready_c got=%b want=1", c_ro); end
    endtask

    task automatic test_latency_255();
        int lat;
        conv_a(8'd255, lat);
        n_checks++; if (lat != 8)          begin n_errors++; $display("FAIL lat_255 got=%0d want=8", lat); end
        n_checks++; if (a_bcd !== 12'h255) begin n_errors++; $display("FAIL bcd_255 got=%h want=255", a_bcd); end
        n_checks++; if (a_ovf !== 1'b0)    begin n_errors++; $display("FAIL ovf_255 got=%b want=0", a_ovf); end
        n_checks++; if (a_ndig !== 2'd3)   begin n_errors++; $display("FAIL ndig_255 got=%0d want=3", a_ndig); end
        a_ri = 1'b1; step(); a_ri = 1'b0;
        n_checks++; if (a_ro !== 1'b1) begin n_errors++; $display("FAIL ready_after_out got=%b want=1", a_ro); end
        n_checks++; if (a_vo !== 1'b0) begin n_errors++; $display("FAIL valid_after_out got=%b want=0", a_vo); end
    endtask

    task automatic test_small();
        logic [7:0]  vals [2] = '{8'd0, 8'd7};
        logic [11:0] exp_b [2] = '{12'h000, 12'h007};
        int lat;
        for (int i = 0; i < 2; i++) begin
            conv_a(vals[i], lat);
            n_checks++; if (a_bcd !== exp_b[i]) begin n_errors++; $display("FAIL small_bcd in=%0d got=%h want=%h", vals[i], a_bcd, exp_b[i]); end
            n_checks++; if (a_ovf !== 1'b0)     begin n_errors++; $display("FAIL small_ovf in=%0d got=%b want=0", vals[i], a_ovf); end
            n_checks++; if (a_ndig !== 2'd1)    begin n_errors++; $display("FAIL small_ndig in=%0d got=%0d want=1", vals[i], a_ndig); end
            a_ri = 1'b1; step(); a_ri = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        conv_a(8'd123, lat);
        a_bin = 8'd9; a_vi = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (a_bcd !== 12'h123) begin n_errors++; $display("FAIL bp_bcd cyc=%0d got=%h want=123", i, a_bcd); end
            n_checks++; if (a_ro !== 1'b0)     begin n_errors++; $display("FAIL bp_ready cyc=%0d got=%b want=0", i, a_ro); end
            n_checks++; if (a_vo !== 1'b1)     begin n_errors++; $display("FAIL bp_valid cyc=%0d got=%b want=1", i, a_vo); end
        end
        a_ri = 1'b1; step(); a_ri = 1'b0; a_vi = 1'b0;
        n_checks++; if (a_ro !== 1'b1) begin n_errors++; $display("FAIL bp_release_ready got=%b want=1", a_ro); end
        n_checks++; if (a_vo !== 1'b0) begin n_errors++; $display("FAIL bp_release_valid got=%b want=0", a_vo); end
        step(); step();
        n_checks++; if (a_ro !== 1'b1)     begin n_errors++; $display("FAIL bp_not_queued got=%b want=1", a_ro); end
        n_checks++; if (a_bcd !== 12'h123) begin n_errors++; $display("FAIL bp_idle_hold got=%h want=123", a_bcd); end
    endtask

    task automatic test_ovf_b();
        int lat;
        conv_b(8'd199, lat);
        n_checks++; if (b_bcd !== 8'h99)  begin n_errors++; $display("FAIL ovf199_bcd got=%h want=99", b_bcd); end
        n_checks++; if (b_ovf !== 1'b1)   begin n_errors++; $display("FAIL ovf199_ovf got=%b want=1", b_ovf); end
        n_checks++; if (b_ndig !== 2'd2)  begin n_errors++; $display("FAIL ovf199_ndig got=%0d want=2", b_ndig); end
        b_ri = 1'b1; step(); b_ri = 1'b0;
        conv_b(8'd99, lat);
        n_checks++; if (b_bcd !== 8'h99)  begin n_errors++; $display("FAIL ovf99_bcd got=%h want=99", b_bcd); end
        n_checks++; if (b_ovf !== 1'b0)   begin n_errors++; $display("FAIL ovf99_ovf got=%b want=0", b_ovf); end
        b_ri = 1'b1; step(); b_ri = 1'b0;
        conv_b(8'd100, lat);
        n_checks++; if (b_bcd !== 8'h00)  begin n_errors++; $display("FAIL ovf100_bcd got=%h want=00", b_bcd); end
        n_checks++; if (b_ovf !== 1'b1)   begin n_errors++; $display("FAIL ovf100_ovf got=%b want=1", b_ovf); end
        n_checks++; if (b_ndig !== 2'd1)  begin n_errors++; $display("FAIL ovf100_ndig got=%0d want=1", b_ndig); end
        b_ri = 1'b1; step(); b_ri = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen = 1'b0;
        a_bin = 8'd200; a_vi = 1'b1;
        step();
        a_vi = 1'b0;
        repeat (4) step();
        a_rst = 1'b1; step(); a_rst = 1'b0;
        n_checks++; if (a_vo !== 1'b0)   begin n_errors++; $display("FAIL mid_rst_valid got=%b want=0", a_vo); end
        n_checks++; if (a_ro !== 1'b1)   begin n_errors++; $display("FAIL mid_rst_ready got=%b want=1", a_ro); end
        n_checks++; if (a_bcd !== 12'h0) begin n_errors++; $display("FAIL mid_rst_bcd got=%h want=000", a_bcd); end
        for (int i = 0; i < 12; i++) begin step(); if (a_vo) seen = 1'b1; end
        n_checks++; if (seen) begin n_errors++; $display("FAIL mid_rst_no_result got=1 want=0"); end
        conv_a(8'd42, lat);
        n_checks++; if (lat != 8)          begin n_errors++; $display("FAIL after_rst_lat got=%0d want=8", lat); end
        n_checks++; if (a_bcd !== 12'h042) begin n_errors++; $display("FAIL after_rst_bcd got=%h want=042", a_bcd); end
        n_checks++; if (a_ndig !== 2'd2)   begin n_errors++; $display("FAIL after_rst_ndig got=%0d want=2", a_ndig); end
        a_ri = 1'b1; step(); a_ri = 1'b0;
    endtask

    task automatic test_wide_c();
        int lat;
        logic [15:0] v;
        conv_c(16'd65535, lat);
        n_checks++; if (lat != 16)            begin n_errors++; $display("FAIL wide_lat got=%0d want=16", lat); end
        n_checks++; if (c_bcd !== 20'h65535)  begin n_errors++; $display("FAIL wide_bcd got=%h want=65535", c_bcd); end
        n_checks++; if (c_ovf !== 1'b0)       begin n_errors++; $display("FAIL wide_ovf got=%b want=0", c_ovf); end
        n_checks++; if (c_ndig !== 3'd5)      begin n_errors++; $display("FAIL wide_ndig got=%0d want=5", c_ndig); end
        c_ri = 1'b1; step(); c_ri = 1'b0;
        for (int i = 0; i < 6; i++) begin
            v = 16'($urandom);
            conv_c(v, lat);
            n_checks++; if (c_bcd !== 20'(m_bcd(v, 5))) begin n_errors++; $display("FAIL wide_rand_bcd in=%0d got=%h want=%h", v, c_bcd, 20'(m_bcd(v, 5))); end
            n_checks++; if (c_ndig !== 3'(m_ndig(v, 5))) begin n_errors++; $display("FAIL wide_rand_ndig in=%0d got=%0d want=%0d", v, c_ndig, m_ndig(v, 5)); end
            c_ri = 1'b1; step(); c_ri = 1'b0;
        end
    endtask

    task automatic test_exhaustive_random();
        int unsigned order [256];
        logic [7:0] q [$];
        logic [7:0] v;
        int nxt = 0, done = 0, cyc = 0;
        bit fire_in, fire_out;
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int unsigned j = $urandom_range(i, 0);
            int unsigned t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        a_vi = 1'b0; a_ri = 1'b0;
        while (done < 256 && cyc < 20000) begin
            if (!a_vi && nxt < 256 && $urandom_range(3, 0) != 0) begin
                a_bin = 8'(order[nxt]);
                a_vi  = 1'b1;
            end
            a_ri = ($urandom_range(2, 0) != 0);
            fire_in  = a_vi && a_ro;
            fire_out = a_vo && a_ri;
            if (fire_out) begin
                if (q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL ex_spurious_valid got=1 want=0");
                end else begin
                    v = q.pop_front();
                    n_checks++; if (a_bcd !== 12'(m_bcd(v, 3))) begin n_errors++; $display("FAIL ex_bcd in=%0d got=%h want=%h", v, a_bcd, 12'(m_bcd(v, 3))); end
                    n_checks++; if (a_ovf !== m_ovf(v, 3))      begin n_errors++; $display("FAIL ex_ovf in=%0d got=%b want=%b", v, a_ovf, m_ovf(v, 3)); end
                    n_checks++; if (a_ndig !== 2'(m_ndig(v, 3))) begin n_errors++; $display("FAIL ex_ndig in=%0d got=%0d want=%0d", v, a_ndig, m_ndig(v, 3)); end
                end
                done++;
            end
            step();
            cyc++;
            if (fire_in) begin
                q.push_back(a_bin);
                nxt++;
                a_vi = 1'b0;
            end
        end
        a_vi = 1'b0; a_ri = 1'b0;
        n_checks++;
        if (done != 256) begin n_errors++; $display("FAIL ex_complete got=%0d want=256", done); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_latency_255();
        test_small();
        test_backpressure();
        test_ovf_b();
        test_reset_mid();
        test_wide_c();
        test_exhaustive_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
